// File: rtl/mc_pkg.sv
// mc_pkg: shared types and helpers for the memory-controller command path.
//   mc_cmd_e    - command code presented by each bank requester
//   dfi_cmd_t   - one DFI phase slot (address, bank, cs_n/ras_n/cas_n/we_n)
//   DFI_NOP     - idle slot value
//   cmd_to_dfi  - maps a command plus bank/address onto a DFI slot
package mc_pkg;

    localparam int unsigned MC_ADDR_W  = 17;
    localparam int unsigned MC_BANK_W  = 3;
    localparam int unsigned MC_CMD_W   = 3;
    localparam int unsigned MC_NPHASE  = 4;

    typedef enum logic [MC_CMD_W-1:0] {
        MC_NOP = 3'd0,
        MC_ACT = 3'd1,
        MC_PRE = 3'd2,
        MC_RD  = 3'd3,
        MC_WR  = 3'd4,
        MC_REF = 3'd5
    } mc_cmd_e;

    typedef struct packed {
        logic [MC_ADDR_W-1:0] address;
        logic [MC_BANK_W-1:0] bank;
        logic                 cs_n;
        logic                 ras_n;
        logic                 cas_n;
        logic                 we_n;
    } dfi_cmd_t;

    localparam dfi_cmd_t DFI_NOP = '{
        address: '0,
        bank:    '0,
        cs_n:    1'b1,
        ras_n:   1'b1,
        cas_n:   1'b1,
        we_n:    1'b1
    };

    // Unknown codes collapse to a plain NOP slot with zero address/bank.
    function automatic dfi_cmd_t cmd_to_dfi(input mc_cmd_e              cmd,
                                            input logic [MC_BANK_W-1:0] bank,
                                            input logic [MC_ADDR_W-1:0] address);
        dfi_cmd_t d;
        d         = DFI_NOP;
        d.address = address;
        d.bank    = bank;
        case (cmd)
            MC_ACT:  {d.cs_n, d.ras_n, d.cas_n, d.we_n} = 4'b0011;
            MC_PRE:  {d.cs_n, d.ras_n, d.cas_n, d.we_n} = 4'b0010;
            MC_RD:   {d.cs_n, d.ras_n, d.cas_n, d.we_n} = 4'b0101;
            MC_WR:   {d.cs_n, d.ras_n, d.cas_n, d.we_n} = 4'b0100;
            MC_REF:  {d.cs_n, d.ras_n, d.cas_n, d.we_n} = 4'b0001;
            default: d = DFI_NOP;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mc_cmd_scheduler_if.sv
// mc_cmd_scheduler_if: bank/refresh request handshake plus the four DFI
// command phase slots driven by the scheduler.
//   req_valid/req_cmd/req_addr, ref_valid : requester -> scheduler
//   req_ready, ref_ready                  : scheduler -> requester (grants)
//   dfi_p{0..3}_*                         : scheduler -> DFI adapter
// modport master = requester/adapter side, modport slave = scheduler.
interface mc_cmd_scheduler_if #(
    parameter int unsigned NBANK  = 8,
    parameter int unsigned ADDR_W = mc_pkg::MC_ADDR_W,
    parameter int unsigned BANK_W = mc_pkg::MC_BANK_W
) ();
    import mc_pkg::*;

    logic [NBANK-1:0]                req_valid;
    logic [NBANK-1:0]                req_ready;
    logic [NBANK-1:0][MC_CMD_W-1:0]  req_cmd;
    logic [NBANK-1:0][ADDR_W-1:0]    req_addr;
    logic                            ref_valid;
    logic                            ref_ready;

    logic [ADDR_W-1:0] dfi_p0_address, dfi_p1_address, dfi_p2_address, dfi_p3_address;
    logic [BANK_W-1:0] dfi_p0_bank,    dfi_p1_bank,    dfi_p2_bank,    dfi_p3_bank;
    logic dfi_p0_cs_n,  dfi_p1_cs_n,  dfi_p2_cs_n,  dfi_p3_cs_n;
    logic dfi_p0_ras_n, dfi_p1_ras_n, dfi_p2_ras_n, dfi_p3_ras_n;
    logic dfi_p0_cas_n, dfi_p1_cas_n, dfi_p2_cas_n, dfi_p3_cas_n;
    logic dfi_p0_we_n,  dfi_p1_we_n,  dfi_p2_we_n,  dfi_p3_we_n;

    modport master (
        output req_valid, req_cmd, req_addr, ref_valid,
        input  req_ready, ref_ready,
        input  dfi_p0_address, dfi_p1_address, dfi_p2_address, dfi_p3_address,
        input  dfi_p0_bank,    dfi_p1_bank,    dfi_p2_bank,    dfi_p3_bank,
        input  dfi_p0_cs_n,    dfi_p1_cs_n,    dfi_p2_cs_n,    dfi_p3_cs_n,
        input  dfi_p0_ras_n,   dfi_p1_ras_n,   dfi_p2_ras_n,   dfi_p3_ras_n,
        input  dfi_p0_cas_n,   dfi_p1_cas_n,   dfi_p2_cas_n,   dfi_p3_cas_n,
        input  dfi_p0_we_n,    dfi_p1_we_n,    dfi_p2_we_n,    dfi_p3_we_n
    );

    modport slave (
        input  req_valid, req_cmd, req_addr, ref_valid,
        output req_ready, ref_ready,
        output dfi_p0_address, dfi_p1_address, dfi_p2_address, dfi_p3_address,
        output dfi_p0_bank,    dfi_p1_bank,    dfi_p2_bank,    dfi_p3_bank,
        output dfi_p0_cs_n,    dfi_p1_cs_n,    dfi_p2_cs_n,    dfi_p3_cs_n,
        output dfi_p0_ras_n,   dfi_p1_ras_n,   dfi_p2_ras_n,   dfi_p3_ras_n,
        output dfi_p0_cas_n,   dfi_p1_cas_n,   dfi_p2_cas_n,   dfi_p3_cas_n,
        output dfi_p0_we_n,    dfi_p1_we_n,    dfi_p2_we_n,    dfi_p3_we_n
    );

endinterface

// File: rtl/mc_rr_arbiter.sv
// mc_rr_arbiter: combinational round-robin arbiter.
//   req_i     - request vector
//   ptr_i     - index where the search starts (highest priority)
//   gnt_o     - one-hot grant (all zero when nothing requests)
//   ptr_nxt_o - winner+1 mod N on a grant, otherwise ptr_i unchanged
module mc_rr_arbiter #(
    parameter  int unsigned N     = 8,
    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [PTR_W-1:0] ptr_nxt_o
);

    logic             found;
    logic [PTR_W-1:0] idx;
    int unsigned      sum;

    // Walk N slots starting at ptr_i; first requester found wins.
    always_comb begin
        gnt_o     = '0;
        ptr_nxt_o = ptr_i;
        found     = 1'b0;
        idx       = '0;
        sum       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            sum = 32'(ptr_i) + k;
            idx = PTR_W'(sum % N);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                ptr_nxt_o  = (idx == PTR_W'(N - 1)) ? '0 : PTR_W'(idx + PTR_W'(1));
            end
        end
    end

endmodule

// File: rtl/mc_cmd_scheduler.sv
// mc_cmd_scheduler: per-cycle DFI command scheduler.
// Grants at most one row command (ACT/PRE/REF) on ROW_PHASE and one column
// command (RD/WR) on COL_PHASE each cycle, round-robin across bank requesters,
// with refresh taking absolute priority. Spacing is enforced by saturating
// down-counters (tRRD, tCCD, tWTR, tRTW, tRFC).
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   bus (slave)      : request/grant handshake in, registered DFI phases out
// Grants (req_ready/ref_ready) are combinational; DFI phases appear one
// cycle after the grant.
module mc_cmd_scheduler
    import mc_pkg::*;
#(
    parameter int unsigned NBANK     = 8,
    parameter int unsigned ADDR_W    = MC_ADDR_W,
    parameter int unsigned BANK_W    = MC_BANK_W,
    parameter int unsigned ROW_PHASE = 0,
    parameter int unsigned COL_PHASE = 2,
    parameter int unsigned T_RRD     = 2,
    parameter int unsigned T_CCD     = 2,
    parameter int unsigned T_WTR     = 4,
    parameter int unsigned T_RTW     = 3,
    parameter int unsigned T_RFC     = 16
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    mc_cmd_scheduler_if.slave   bus
);

    localparam int unsigned PTR_W = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam int unsigned RRD_W = $clog2(T_RRD + 1);
    localparam int unsigned CCD_W = $clog2(T_CCD + 1);
    localparam int unsigned WTR_W = $clog2(T_WTR + 1);
    localparam int unsigned RTW_W = $clog2(T_RTW + 1);
    localparam int unsigned RFC_W = $clog2(T_RFC + 1);
    localparam logic [1:0]  ROW_IDX = 2'(ROW_PHASE);
    localparam logic [1:0]  COL_IDX = 2'(COL_PHASE);

    logic [PTR_W-1:0] row_ptr_q, row_ptr_d;
    logic [PTR_W-1:0] col_ptr_q, col_ptr_d;
    logic [RRD_W-1:0] rrd_cnt_q, rrd_cnt_d;
    logic [CCD_W-1:0] ccd_cnt_q, ccd_cnt_d;
    logic [WTR_W-1:0] wtr_cnt_q, wtr_cnt_d;
    logic [RTW_W-1:0] rtw_cnt_q, rtw_cnt_d;
    logic [RFC_W-1:0] rfc_cnt_q, rfc_cnt_d;

    dfi_cmd_t [MC_NPHASE-1:0] dfi_q, dfi_d;

    logic [NBANK-1:0] is_act, is_pre, is_rd, is_wr;
    logic [NBANK-1:0] row_req, col_req, row_gnt, col_gnt;
    logic             block_all;
    logic             ref_grant;
    logic             act_issue, rd_issue, wr_issue;

    // Decode per-requester commands; unknown codes never qualify.
    always_comb begin
        is_act = '0;
        is_pre = '0;
        is_rd  = '0;
        is_wr  = '0;
        for (int unsigned i = 0; i < NBANK; i++) begin
            is_act[i] = bus.req_valid[i] && (mc_cmd_e'(bus.req_cmd[i]) == MC_ACT);
            is_pre[i] = bus.req_valid[i] && (mc_cmd_e'(bus.req_cmd[i]) == MC_PRE);
            is_rd[i]  = bus.req_valid[i] && (mc_cmd_e'(bus.req_cmd[i]) == MC_RD);
            is_wr[i]  = bus.req_valid[i] && (mc_cmd_e'(bus.req_cmd[i]) == MC_WR);
        end
    end

    // Refresh request or tRFC in flight freezes every bank grant (and the pointers).
    assign block_all = sys_rst || bus.ref_valid || (rfc_cnt_q != '0);
    assign ref_grant = bus.ref_valid && !sys_rst && (rfc_cnt_q == '0) && (ccd_cnt_q == '0);

    // Eligibility after timing constraints.
    always_comb begin
        row_req = '0;
        col_req = '0;
        if (!block_all) begin
            row_req = is_pre | (is_act & {NBANK{rrd_cnt_q == '0}});
            if (ccd_cnt_q == '0) begin
                col_req = (is_rd & {NBANK{wtr_cnt_q == '0}})
                        | (is_wr & {NBANK{rtw_cnt_q == '0}});
            end
        end
    end

    mc_rr_arbiter #(.N(NBANK)) u_row_arb (
        .req_i     (row_req),
        .ptr_i     (row_ptr_q),
        .gnt_o     (row_gnt),
        .ptr_nxt_o (row_ptr_d)
    );

    mc_rr_arbiter #(.N(NBANK)) u_col_arb (
        .req_i     (col_req),
        .ptr_i     (col_ptr_q),
        .gnt_o     (col_gnt),
        .ptr_nxt_o (col_ptr_d)
    );

    assign bus.req_ready = row_gnt | col_gnt;
    assign bus.ref_ready = ref_grant;

    assign act_issue = |(row_gnt & is_act);
    assign rd_issue  = |(col_gnt & is_rd);
    assign wr_issue  = |(col_gnt & is_wr);

    // Spacing counters: load T-1 on issue, otherwise count down to zero.
    always_comb begin
        rrd_cnt_d = (rrd_cnt_q != '0) ? rrd_cnt_q - RRD_W'(1) : '0;
        ccd_cnt_d = (ccd_cnt_q != '0) ? ccd_cnt_q - CCD_W'(1) : '0;
        wtr_cnt_d = (wtr_cnt_q != '0) ? wtr_cnt_q - WTR_W'(1) : '0;
        rtw_cnt_d = (rtw_cnt_q != '0) ? rtw_cnt_q - RTW_W'(1) : '0;
        rfc_cnt_d = (rfc_cnt_q != '0) ? rfc_cnt_q - RFC_W'(1) : '0;
        if (act_issue)            rrd_cnt_d = RRD_W'(T_RRD - 1);
        if (rd_issue || wr_issue) ccd_cnt_d = CCD_W'(T_CCD - 1);
        if (wr_issue)             wtr_cnt_d = WTR_W'(T_WTR - 1);
        if (rd_issue)             rtw_cnt_d = RTW_W'(T_RTW - 1);
        if (ref_grant)            rfc_cnt_d = RFC_W'(T_RFC - 1);
    end

    // Next DFI slot contents; bank index driven is the requester index.
    always_comb begin
        for (int unsigned p = 0; p < MC_NPHASE; p++) begin
            dfi_d[p] = DFI_NOP;
        end
        if (ref_grant) begin
            dfi_d[ROW_IDX] = cmd_to_dfi(MC_REF, '0, '0);
        end
        for (int unsigned i = 0; i < NBANK; i++) begin
            if (row_gnt[i]) begin
                dfi_d[ROW_IDX] = cmd_to_dfi(mc_cmd_e'(bus.req_cmd[i]), MC_BANK_W'(i),
                                            MC_ADDR_W'(bus.req_addr[i]));
            end
            if (col_gnt[i]) begin
                dfi_d[COL_IDX] = cmd_to_dfi(mc_cmd_e'(bus.req_cmd[i]), MC_BANK_W'(i),
                                            MC_ADDR_W'(bus.req_addr[i]));
            end
        end
    end

    // State registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            row_ptr_q <= '0;
            col_ptr_q <= '0;
            rrd_cnt_q <= '0;
            ccd_cnt_q <= '0;
            wtr_cnt_q <= '0;
            rtw_cnt_q <= '0;
            rfc_cnt_q <= '0;
            for (int unsigned p = 0; p < MC_NPHASE; p++) begin
                dfi_q[p] <= DFI_NOP;
            end
        end else begin
            row_ptr_q <= row_ptr_d;
            col_ptr_q <= col_ptr_d;
            rrd_cnt_q <= rrd_cnt_d;
            ccd_cnt_q <= ccd_cnt_d;
            wtr_cnt_q <= wtr_cnt_d;
            rtw_cnt_q <= rtw_cnt_d;
            rfc_cnt_q <= rfc_cnt_d;
            dfi_q     <= dfi_d;
        end
    end

    // Flatten registered slots onto the named DFI ports.
    assign bus.dfi_p0_address = ADDR_W'(dfi_q[0].address);
    assign bus.dfi_p1_address = ADDR_W'(dfi_q[1].address);
    assign bus.dfi_p2_address = ADDR_W'(dfi_q[2].address);
    assign bus.dfi_p3_address = ADDR_W'(dfi_q[3].address);
    assign bus.dfi_p0_bank    = BANK_W'(dfi_q[0].bank);
    assign bus.dfi_p1_bank    = BANK_W'(dfi_q[1].bank);
    assign bus.dfi_p2_bank    = BANK_W'(dfi_q[2].bank);
    assign bus.dfi_p3_bank    = BANK_W'(dfi_q[3].bank);
    assign bus.dfi_p0_cs_n    = dfi_q[0].cs_n;
    assign bus.dfi_p1_cs_n    = dfi_q[1].cs_n;
    assign bus.dfi_p2_cs_n    = dfi_q[2].cs_n;
    assign bus.dfi_p3_cs_n    = dfi_q[3].cs_n;
    assign bus.dfi_p0_ras_n   = dfi_q[0].ras_n;
    assign bus.dfi_p1_ras_n   = dfi_q[1].ras_n;
    assign bus.dfi_p2_ras_n   = dfi_q[2].ras_n;
    assign bus.dfi_p3_ras_n   = dfi_q[3].ras_n;
    assign bus.dfi_p0_cas_n   = dfi_q[0].cas_n;
    assign bus.dfi_p1_cas_n   = dfi_q[1].cas_n;
    assign bus.dfi_p2_cas_n   = dfi_q[2].cas_n;
    assign bus.dfi_p3_cas_n   = dfi_q[3].cas_n;
    assign bus.dfi_p0_we_n    = dfi_q[0].we_n;
    assign bus.dfi_p1_we_n    = dfi_q[1].we_n;
    assign bus.dfi_p2_we_n    = dfi_q[2].we_n;
    assign bus.dfi_p3_we_n    = dfi_q[3].we_n;

endmodule

// File: tb/tb_mc_cmd_scheduler.sv
// tb_mc_cmd_scheduler: directed scenarios for mc_cmd_scheduler with
// hand-computed grant vectors and DFI slot contents.
module tb_mc_cmd_scheduler;
    import mc_pkg::*;

    localparam logic [3:0] E_NOP = 4'b1111;
    localparam logic [3:0] E_ACT = 4'b0011;
    localparam logic [3:0] E_PRE = 4'b0010;
    localparam logic [3:0] E_RD  = 4'b0101;
    localparam logic [3:0] E_WR  = 4'b0100;
    localparam logic [3:0] E_REF = 4'b0001;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   errors  = 0;
    int   checks  = 0;

    always #5 sys_clk = ~sys_clk;

    mc_cmd_scheduler_if #(.NBANK(8), .ADDR_W(17), .BANK_W(3)) bus ();

    mc_cmd_scheduler dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    // Phase slot packed as {address, bank, cs_n, ras_n, cas_n, we_n}.
    function automatic logic [23:0] ph(input int p);
        case (p)
            0:       return {bus.dfi_p0_address, bus.dfi_p0_bank, bus.dfi_p0_cs_n,
                             bus.dfi_p0_ras_n, bus.dfi_p0_cas_n, bus.dfi_p0_we_n};
            1:       return {bus.dfi_p1_address, bus.dfi_p1_bank, bus.dfi_p1_cs_n,
                             bus.dfi_p1_ras_n, bus.dfi_p1_cas_n, bus.dfi_p1_we_n};
            2:       return {bus.dfi_p2_address, bus.dfi_p2_bank, bus.dfi_p2_cs_n,
                             bus.dfi_p2_ras_n, bus.dfi_p2_cas_n, bus.dfi_p2_we_n};
            default: return {bus.dfi_p3_address, bus.dfi_p3_bank, bus.dfi_p3_cs_n,
                             bus.dfi_p3_ras_n, bus.dfi_p3_cas_n, bus.dfi_p3_we_n};
        endcase
    endfunction

    function automatic logic [23:0] mk(input logic [3:0] enc, input logic [2:0] bank,
                                       input logic [16:0] addr);
        return {addr, bank, enc};
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid = '0;
        bus.req_cmd   = '0;
        bus.req_addr  = '0;
        bus.ref_valid = 1'b0;
    endtask

    task automatic set_req(input int i, input mc_cmd_e cmd, input logic [16:0] addr);
        bus.req_valid[i] = 1'b1;
        bus.req_cmd[i]   = cmd;
        bus.req_addr[i]  = addr;
    endtask

    task automatic do_reset();
        idle_inputs();
        sys_rst = 1'b1;
        tick();
        tick();
        sys_rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.req_valid = '1;
        for (int i = 0; i < 8; i++) bus.req_cmd[i] = MC_ACT;
        bus.ref_valid = 1'b1;
        sys_rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (bus.req_ready !== 8'h00) begin
                errors++;
                $display("FAIL reset_req_ready c%0d: got %h expected 00", c, bus.req_ready);
            end
            checks++;
            if (bus.ref_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_ref_ready c%0d: got %b expected 0", c, bus.ref_ready);
            end
            for (int p = 0; p < 4; p++) begin
                checks++;
                if (ph(p) !== mk(E_NOP, 3'd0, 17'd0)) begin
                    errors++;
                    $display("FAIL reset_phase%0d c%0d: got %h expected %h", p, c, ph(p),
                             mk(E_NOP, 3'd0, 17'd0));
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_round_robin_act();
        logic [7:0]  exp_rdy [6];
        logic [23:0] exp_p0  [6];
        exp_rdy = '{8'h01, 8'h00, 8'h08, 8'h00, 8'h20, 8'h00};
        exp_p0[0] = mk(E_NOP, 3'd0, 17'd0);
        exp_p0[1] = mk(E_ACT, 3'd0, 17'h100);
        exp_p0[2] = mk(E_NOP, 3'd0, 17'd0);
        exp_p0[3] = mk(E_ACT, 3'd3, 17'h103);
        exp_p0[4] = mk(E_NOP, 3'd0, 17'd0);
        exp_p0[5] = mk(E_ACT, 3'd5, 17'h105);
        do_reset();
        set_req(0, MC_ACT, 17'h100);
        set_req(3, MC_ACT, 17'h103);
        set_req(5, MC_ACT, 17'h105);
        for (int c = 0; c < 6; c++) begin
            if (c > 0) begin
                tick();
                bus.req_valid = bus.req_valid & ~exp_rdy[c-1];
            end
            #1;
            checks++;
            if (bus.req_ready !== exp_rdy[c]) begin
                errors++;
                $display("FAIL rr_act_ready c%0d: got %h expected %h", c, bus.req_ready, exp_rdy[c]);
            end
            checks++;
            if (ph(0) !== exp_p0[c]) begin
                errors++;
                $display("FAIL rr_act_p0 c%0d: got %h expected %h", c, ph(0), exp_p0[c]);
            end
        end
    endtask

    task automatic test_parallel_row_col();
        logic [23:0] exp_ph [4];
        exp_ph[0] = mk(E_PRE, 3'd1, 17'h0AA);
        exp_ph[1] = mk(E_NOP, 3'd0, 17'd0);
        exp_ph[2] = mk(E_RD,  3'd2, 17'h040);
        exp_ph[3] = mk(E_NOP, 3'd0, 17'd0);
        do_reset();
        set_req(1, MC_PRE, 17'h0AA);
        set_req(2, MC_RD,  17'h040);
        #1;
        checks++;
        if (bus.req_ready !== 8'h06) begin
            errors++;
            $display("FAIL par_ready: got %h expected 06", bus.req_ready);
        end
        tick();
        bus.req_valid = '0;
        #1;
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (ph(p) !== exp_ph[p]) begin
                errors++;
                $display("FAIL par_phase%0d: got %h expected %h", p, ph(p), exp_ph[p]);
            end
        end
    endtask

    task automatic test_wr_to_rd();
        logic [7:0]  exp_rdy [6];
        logic [23:0] exp_p2  [6];
        exp_rdy = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00};
        for (int c = 0; c < 6; c++) exp_p2[c] = mk(E_NOP, 3'd0, 17'd0);
        exp_p2[1] = mk(E_WR, 3'd4, 17'h010);
        exp_p2[5] = mk(E_RD, 3'd6, 17'h020);
        do_reset();
        set_req(4, MC_WR, 17'h010);
        set_req(6, MC_RD, 17'h020);
        for (int c = 0; c < 6; c++) begin
            if (c > 0) begin
                tick();
                bus.req_valid = bus.req_valid & ~exp_rdy[c-1];
            end
            #1;
            checks++;
            if (bus.req_ready !== exp_rdy[c]) begin
                errors++;
                $display("FAIL wtr_ready c%0d: got %h expected %h", c, bus.req_ready, exp_rdy[c]);
            end
            checks++;
            if (ph(2) !== exp_p2[c]) begin
                errors++;
                $display("FAIL wtr_p2 c%0d: got %h expected %h", c, ph(2), exp_p2[c]);
            end
        end
    endtask

    task automatic test_refresh_priority();
        logic [7:0] exp_rdy;
        do_reset();
        set_req(7, MC_ACT, 17'h1FF);
        bus.ref_valid = 1'b1;
        #1;
        checks++;
        if (bus.ref_ready !== 1'b1) begin
            errors++;
            $display("FAIL ref_grant: got %b expected 1", bus.ref_ready);
        end
        checks++;
        if (bus.req_ready !== 8'h00) begin
            errors++;
            $display("FAIL ref_blocks_bank: got %h expected 00", bus.req_ready);
        end
        tick();
        bus.ref_valid = 1'b0;
        #1;
        checks++;
        if (ph(0) !== mk(E_REF, 3'd0, 17'd0)) begin
            errors++;
            $display("FAIL ref_p0: got %h expected %h", ph(0), mk(E_REF, 3'd0, 17'd0));
        end
        for (int c = 1; c <= 16; c++) begin
            if (c > 1) begin
                tick();
                #1;
            end
            exp_rdy = (c == 16) ? 8'h80 : 8'h00;
            checks++;
            if (bus.req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rfc_ready c%0d: got %h expected %h", c, bus.req_ready, exp_rdy);
            end
        end
        tick();
        bus.req_valid = '0;
        #1;
        checks++;
        if (ph(0) !== mk(E_ACT, 3'd7, 17'h1FF)) begin
            errors++;
            $display("FAIL rfc_act_p0: got %h expected %h", ph(0), mk(E_ACT, 3'd7, 17'h1FF));
        end
    endtask

    task automatic test_reset_mid_refresh();
        do_reset();
        set_req(2, MC_ACT, 17'h055);
        bus.ref_valid = 1'b1;
        #1;
        checks++;
        if (bus.ref_ready !== 1'b1) begin
            errors++;
            $display("FAIL midref_grant: got %b expected 1", bus.ref_ready);
        end
        tick();
        bus.ref_valid = 1'b0;
        for (int c = 2; c <= 5; c++) tick();
        #1;
        checks++;
        if (bus.req_ready !== 8'h00) begin
            errors++;
            $display("FAIL midref_blocked: got %h expected 00", bus.req_ready);
        end
        sys_rst = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 8'h00) begin
            errors++;
            $display("FAIL midref_rst_ready: got %h expected 00", bus.req_ready);
        end
        tick();
        sys_rst = 1'b0;
        #1;
        checks++;
        if (ph(0) !== mk(E_NOP, 3'd0, 17'd0)) begin
            errors++;
            $display("FAIL midref_rst_p0: got %h expected %h", ph(0), mk(E_NOP, 3'd0, 17'd0));
        end
        checks++;
        if (bus.req_ready !== 8'h04) begin
            errors++;
            $display("FAIL midref_act_ready: got %h expected 04", bus.req_ready);
        end
        tick();
        bus.req_valid = '0;
        #1;
        checks++;
        if (ph(0) !== mk(E_ACT, 3'd2, 17'h055)) begin
            errors++;
            $display("FAIL midref_act_p0: got %h expected %h", ph(0), mk(E_ACT, 3'd2, 17'h055));
        end
    endtask

    task automatic test_pointer_wrap();
        do_reset();
        set_req(7, MC_PRE, 17'h007);
        #1;
        checks++;
        if (bus.req_ready !== 8'h80) begin
            errors++;
            $display("FAIL wrap_first: got %h expected 80", bus.req_ready);
        end
        tick();
        // Bank 7 re-requests alongside bank 1: a wrapped pointer (0) favours bank 1.
        set_req(1, MC_PRE, 17'h001);
        set_req(7, MC_PRE, 17'h017);
        #1;
        checks++;
        if (bus.req_ready !== 8'h02) begin
            errors++;
            $display("FAIL wrap_second: got %h expected 02", bus.req_ready);
        end
        tick();
        bus.req_valid[1] = 1'b0;
        #1;
        checks++;
        if (ph(0) !== mk(E_PRE, 3'd1, 17'h001)) begin
            errors++;
            $display("FAIL wrap_p0: got %h expected %h", ph(0), mk(E_PRE, 3'd1, 17'h001));
        end
        checks++;
        if (bus.req_ready !== 8'h80) begin
            errors++;
            $display("FAIL wrap_third: got %h expected 80", bus.req_ready);
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        test_reset();
        test_round_robin_act();
        test_parallel_row_col();
        test_wr_to_rd();
        test_refresh_priority();
        test_reset_mid_refresh();
        test_pointer_wrap();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
